// File: rtl/regfile_wb_writer.sv
// Register-file write-back driver: MEM/WB has priority, multi-cycle results queue in a FIFO.
// Define WB_FWD_EN to add the write-through bypass ports.
module regfile_wb_writer #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int DW           = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipe_we,
  input  logic [4:0]    pipe_addr,
  input  logic [DW-1:0] pipe_data,
  output logic          pipe_stall,
  input  logic          mc_valid,
  output logic          mc_ready,
  input  logic [4:0]    mc_addr,
  input  logic [DW-1:0] mc_data,
  output logic          wr_en,
  output logic [4:0]    wr_addr,
  output logic [DW-1:0] wr_data,
`ifdef WB_FWD_EN
  input  logic [4:0]    rd_addr1,
  input  logic [4:0]    rd_addr2,
  output logic          fwd_hit1,
  output logic          fwd_hit2,
  output logic [DW-1:0] fwd_data1,
  output logic [DW-1:0] fwd_data2,
`endif
  output logic [31:0]   busy_mask
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);
  localparam logic [SW-1:0] L_LIM   = SW'(STARVE_LIMIT);

  logic [4:0]    r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_starve;

  logic w_ne;
  logic w_pipe_win;
  logic w_pop;
  logic w_push;

  assign w_ne       = (r_cnt != '0);
  assign mc_ready   = (r_cnt < L_DEPTH);
  assign pipe_stall = (r_starve == L_LIM) && w_ne;
  assign w_pipe_win = !pipe_stall && pipe_we && (pipe_addr != 5'd0);
  assign w_pop      = !w_pipe_win && w_ne;
  // Handshakes to x0 complete but are dropped here.
  assign w_push     = mc_valid && mc_ready && (mc_addr != 5'd0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wp] <= mc_addr;
      r_data[r_wp] <= mc_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
      r_starve <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop)
        r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop)
        r_cnt <= r_cnt - 1'b1;

      if (w_pop || !w_ne)
        r_starve <= '0;
      else if (w_pipe_win && r_starve != L_LIM)
        r_starve <= r_starve + 1'b1;

      wr_en <= w_pipe_win || w_pop;
      if (w_pipe_win) begin
        wr_addr <= pipe_addr;
        wr_data <= pipe_data;
      end else if (w_pop) begin
        wr_addr <= r_addr[r_rp];
        wr_data <= r_data[r_rp];
      end
    end
  end

  // Slot i is live when its distance from the read pointer is below count.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, PW'(PW'(i) - r_rp)} < r_cnt)
        busy_mask[r_addr[i]] = 1'b1;
    end
  end

`ifdef WB_FWD_EN
  assign fwd_hit1  = wr_en && (wr_addr == rd_addr1) && (rd_addr1 != 5'd0);
  assign fwd_hit2  = wr_en && (wr_addr == rd_addr2) && (rd_addr2 != 5'd0);
  assign fwd_data1 = wr_data;
  assign fwd_data2 = wr_data;
`endif

endmodule

// File: tb/tb_regfile_wb_writer.sv
// Randomized + directed bench for regfile_wb_writer against a queue-based model.
module tb_regfile_wb_writer;
  localparam int DW  = 32;
  localparam int LIM = 8;
  localparam int DEP = 4;

  logic          clk = 0;
  logic          rst = 1;
  logic          pipe_we = 0;
  logic [4:0]    pipe_addr = 0;
  logic [DW-1:0] pipe_data = 0;
  logic          pipe_stall;
  logic          mc_valid = 0;
  logic          mc_ready;
  logic [4:0]    mc_addr = 0;
  logic [DW-1:0] mc_data = 0;
  logic          wr_en;
  logic [4:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic [31:0]   busy_mask;
`ifdef WB_FWD_EN
  logic [4:0]    rd_addr1 = 0;
  logic [4:0]    rd_addr2 = 0;
  logic          fwd_hit1, fwd_hit2;
  logic [DW-1:0] fwd_data1, fwd_data2;
`endif

  regfile_wb_writer #(.DEPTH(DEP), .STARVE_LIMIT(LIM), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .pipe_stall(pipe_stall),
    .mc_valid(mc_valid), .mc_ready(mc_ready),
    .mc_addr(mc_addr), .mc_data(mc_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef WB_FWD_EN
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
`endif
    .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t q[$];
  int   starve = 0;
  logic m_en = 0;
  logic [4:0]  m_addr = 0;
  logic [31:0] m_data = 0;
  logic last_stall = 0;
  int   n_wr = 0;
  int   n_stall = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_mask();
    logic [31:0] m = 0;
    foreach (q[i]) m[q[i].a] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    q.delete();
    starve = 0;
    m_en = 0; m_addr = 0; m_data = 0;
  endtask

  // Compare combinational outputs, advance model, clock, compare registered outputs.
  task automatic step();
    logic stall, ready, pwin, ne;
    ne    = q.size() > 0;
    stall = (starve == LIM) && ne;
    ready = q.size() < DEP;
    chk("pipe_stall", 32'(pipe_stall), 32'(stall));
    chk("mc_ready", 32'(mc_ready), 32'(ready));
    chk("busy_mask", busy_mask, m_mask());
    last_stall = stall;
    if (stall) n_stall++;
    pwin = !stall && pipe_we && pipe_addr != 0;
    if (pwin) begin
      m_en = 1; m_addr = pipe_addr; m_data = pipe_data;
    end else if (ne) begin
      m_en = 1; m_addr = q[0].a; m_data = q[0].d;
      void'(q.pop_front());
    end else begin
      m_en = 0;
    end
    if (ne && pwin) starve = (starve < LIM) ? starve + 1 : LIM;
    else starve = 0;
    if (mc_valid && ready && mc_addr != 0)
      q.push_back('{mc_addr, mc_data});
    @(posedge clk); #1;
    if (m_en) n_wr++;
    chk("wr_en", 32'(wr_en), 32'(m_en));
    chk("wr_addr", 32'(wr_addr), 32'(m_addr));
    chk("wr_data", wr_data, m_data);
  endtask

  task automatic idle();
    pipe_we = 0; mc_valid = 0;
  endtask

  initial begin
    int seen;
    #2;
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_ready", 32'(mc_ready), 1);
    chk("rst_stall", 32'(pipe_stall), 0);
    chk("rst_mask", busy_mask, 0);
    @(posedge clk); #1;
    rst = 0;
    model_reset();

    // single pipe write
    pipe_we = 1; pipe_addr = 5; pipe_data = 32'h1234;
    step();
    idle();
    step();
    chk("t1_wr_en_drop", 32'(wr_en), 0);

    // two mc writes in order
    mc_valid = 1; mc_addr = 7; mc_data = 32'hA;
    step();
    mc_addr = 8; mc_data = 32'hB;
    step();
    chk("t2_first", 32'(wr_addr), 7);
    idle();
    step();
    chk("t2_second", 32'(wr_addr), 8);
    step();

    // x0 writes are dropped
    n_wr = 0;
    pipe_we = 1; pipe_addr = 0; pipe_data = 32'hFFFF;
    mc_valid = 1; mc_addr = 0; mc_data = 32'h55;
    step(); step();
    idle();
    step();
    chk("t3_no_wr", 32'(n_wr), 0);

    // starvation: pipe always requests while FIFO fills
    n_stall = 0;
    pipe_we = 1; pipe_addr = 3; pipe_data = 32'h33;
    mc_valid = 1;
    for (int i = 0; i < 4; i++) begin
      mc_addr = 5'(10 + i); mc_data = 32'(100 + i);
      step();
    end
    mc_valid = 0;
    chk("t4_full", 32'(mc_ready), 0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (last_stall) seen = 1;
    end
    chk("t4_stall_seen", 32'(seen), 1);
    chk("t4_head_wr", 32'(wr_addr), 10);
    idle();
    while (q.size() > 0) step();
    step();

    // reset mid-operation
    pipe_we = 1; pipe_addr = 4; pipe_data = 32'h44;
    mc_valid = 1;
    for (int i = 0; i < 3; i++) begin
      mc_addr = 5'(20 + i); mc_data = 32'(200 + i);
      step();
    end
    idle();
    #2 rst = 1;
    #1;
    chk("t5_wr_en", 32'(wr_en), 0);
    chk("t5_mask", busy_mask, 0);
    chk("t5_ready", 32'(mc_ready), 1);
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    n_wr = 0;
    step(); step(); step();
    chk("t5_no_replay", 32'(n_wr), 0);

`ifdef WB_FWD_EN
    pipe_we = 1; pipe_addr = 9; pipe_data = 32'h55;
    step();
    idle();
    rd_addr1 = 9; rd_addr2 = 0;
    #1;
    chk("fwd_hit1", 32'(fwd_hit1), 1);
    chk("fwd_data1", fwd_data1, 32'h55);
    chk("fwd_hit2", 32'(fwd_hit2), 0);
    step();
`endif

    // randomized traffic; a stalled pipe request is held for replay
    for (int i = 0; i < 600; i++) begin
      if (!last_stall) begin
        pipe_we   = ($urandom_range(0, 99) < 60);
        pipe_addr = 5'($urandom_range(0, 31));
        pipe_data = $urandom;
      end
      mc_valid = ($urandom_range(0, 99) < 45);
      mc_addr  = 5'($urandom_range(0, 31));
      mc_data  = $urandom;
      #1;
      step();
    end
    idle();
    for (int i = 0; i < 8; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1);
  end
endmodule
